// File: rtl/car_park_pkg.sv
// Shared definitions for the multi-lane car park occupancy counter:
// lane FSM state encodings, sensor pattern constants and the lane
// next-state decode used by every lane instance.
package car_park_pkg;

    // Upper bound on lane count; sizes the per-cycle popcount.
    localparam int MAX_LANES = 8;
    localparam int POP_W     = $clog2(MAX_LANES + 1);

    // Lane direction FSM states. WAITING must stay 0 so a cleared
    // register is the idle lane.
    typedef enum logic [3:0] {
        S_WAITING  = 4'd0,
        S_IN1      = 4'd1,
        S_IN2      = 4'd2,
        S_IN3      = 4'd3,
        S_IN_DONE  = 4'd4,
        S_OUT1     = 4'd5,
        S_OUT2     = 4'd6,
        S_OUT3     = 4'd7,
        S_OUT_DONE = 4'd8
    } lane_state_e;

    // Filtered sensor patterns, packed as {a, b}.
    localparam logic [1:0] PAT_IDLE  = 2'b00;
    localparam logic [1:0] PAT_OUTER = 2'b10;
    localparam logic [1:0] PAT_BOTH  = 2'b11;
    localparam logic [1:0] PAT_INNER = 2'b01;

    // Next lane state for a filtered {a, b} pattern. Any pattern not
    // listed for a state (including two-bit jumps) holds the state.
    function automatic lane_state_e lane_next(input lane_state_e s,
                                              input logic [1:0]  ab);
        lane_state_e n;
        n = s;
        case (s)
            S_WAITING: begin
                if (ab == PAT_OUTER)      n = S_IN1;
                else if (ab == PAT_INNER) n = S_OUT1;
            end
            S_IN1: begin
                if (ab == PAT_BOTH)       n = S_IN2;
                else if (ab == PAT_IDLE)  n = S_WAITING;
            end
            S_IN2: begin
                if (ab == PAT_INNER)      n = S_IN3;
                else if (ab == PAT_OUTER) n = S_IN1;
            end
            S_IN3: begin
                if (ab == PAT_IDLE)       n = S_IN_DONE;
                else if (ab == PAT_BOTH)  n = S_IN2;
            end
            S_OUT1: begin
                if (ab == PAT_BOTH)       n = S_OUT2;
                else if (ab == PAT_IDLE)  n = S_WAITING;
            end
            S_OUT2: begin
                if (ab == PAT_OUTER)      n = S_OUT3;
                else if (ab == PAT_INNER) n = S_OUT1;
            end
            S_OUT3: begin
                if (ab == PAT_IDLE)       n = S_OUT_DONE;
                else if (ab == PAT_BOTH)  n = S_OUT2;
            end
            S_IN_DONE, S_OUT_DONE: n = S_WAITING;
            // Unused encodings recover to idle.
            default:                      n = S_WAITING;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/car_park_lane.sv
// One entry/exit lane: debounce of the a/b photo sensors, the direction
// FSM and the stall timeout. Emits registered one-cycle enter, exit and
// fault pulses.
module car_park_lane
    import car_park_pkg::*;
#(
    parameter int DB_CYCLES      = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic enter,
    output logic exit,
    output logic fault
);

    localparam int DB_W     = $clog2(DB_CYCLES + 1);
    localparam int DB_LAST  = DB_CYCLES - 1;
    localparam int TMO_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [1:0]            raw;
    logic [1:0]            filt_q, filt_d;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

    lane_state_e           state_q, state_d, state_nx;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  enter_q, enter_d;
    logic                  exit_q, exit_d;
    logic                  fault_q, fault_d;

    assign raw = {a, b};

    // Debounce: a filtered bit flips only after DB_CYCLES consecutive
    // samples that disagree with it; any agreeing sample restarts the run.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        filt_d   = filt_q;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (raw[i] != filt_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DB_LAST)) begin
                    filt_d[i] = raw[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Direction FSM plus stall timeout; pulse outputs are decoded from
    // the next state so they are registered alongside it.
    always_comb begin
        state_nx = lane_next(state_q, filt_q);
        state_d  = state_nx;
        tmo_d    = '0;
        fault_d  = 1'b0;
        // The timer runs only while a non-idle state is held; any state
        // change or idling restarts it from zero.
        if ((TIMEOUT_CYCLES != 0) && (state_nx == state_q) && (state_q != S_WAITING)) begin
            if (tmo_q == TMO_W'(TMO_LAST)) begin
                state_d = S_WAITING;
                fault_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
        enter_d = (state_d == S_IN_DONE);
        exit_d  = (state_d == S_OUT_DONE);
    end

    // Lane state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples
        // the pre-edge value of its inputs, independent of statement order.
        if (reset) begin
            filt_q   <= '0;
            db_cnt_q <= '0;
            state_q  <= S_WAITING;
            tmo_q    <= '0;
            enter_q  <= 1'b0;
            exit_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            filt_q   <= filt_d;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            enter_q  <= enter_d;
            exit_q   <= exit_d;
            fault_q  <= fault_d;
        end
    end

    assign enter = enter_q;
    assign exit  = exit_q;
    assign fault = fault_q;

endmodule

// File: rtl/car_park_multi_counter.sv
// Multi-lane car park occupancy counter. Each lane decodes its own
// sensor pair; completed entries and exits are netted each cycle into a
// saturating occupancy count with full/empty flags and a clamp pulse.
module car_park_multi_counter
    import car_park_pkg::*;
#(
    parameter int  N_LANES        = 2,
    parameter int  CAPACITY       = 15,
    parameter int  DB_CYCLES      = 4,
    parameter int  TIMEOUT_CYCLES = 1000,
    localparam int CNT_W          = $clog2(CAPACITY + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_LANES-1:0] a,
    input  logic [N_LANES-1:0] b,
    output logic [N_LANES-1:0] enter,
    output logic [N_LANES-1:0] exit,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output logic [N_LANES-1:0] fault,
    output logic               sat_err
);

    // Signed headroom wide enough for count + MAX_LANES and for
    // 0 - MAX_LANES without wrapping.
    localparam int                      SUM_W = CNT_W + POP_W + 1;
    localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

    logic [POP_W-1:0]        n_in, n_out;
    logic signed [SUM_W-1:0] sum;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    sat_q, sat_d;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        car_park_lane #(
            .DB_CYCLES      (DB_CYCLES),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .a     (a[i]),
            .b     (b[i]),
            .enter (enter[i]),
            .exit  (exit[i]),
            .fault (fault[i])
        );
    end

    // Net all lane pulses this cycle and clamp the result into range.
    always_comb begin
        n_in  = '0;
        n_out = '0;
        for (int i = 0; i < N_LANES; i++) begin
            n_in  = n_in  + POP_W'(enter[i]);
            n_out = n_out + POP_W'(exit[i]);
        end
        sum = $signed(SUM_W'(count_q)) + $signed(SUM_W'(n_in)) - $signed(SUM_W'(n_out));

        count_d = count_q;
        sat_d   = 1'b0;
        if (sum[SUM_W-1]) begin
            count_d = '0;
            sat_d   = 1'b1;
        end else if (sum > CAP_S) begin
            count_d = CNT_W'(CAPACITY);
            sat_d   = 1'b1;
        end else begin
            count_d = sum[CNT_W-1:0];
        end
    end

    // Occupancy count and clamp pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count   = count_q;
    assign full    = (count_q == CNT_W'(CAPACITY));
    assign empty   = (count_q == '0);
    assign sat_err = sat_q;

endmodule

// File: doc/car_park_multi_counter.md
Name: car_park_multi_counter

Overview:
- Multi-lane successor to the single-lane parking occupancy sensor: N_LANES independent a/b photo-sensor pairs, each debounced and decoded by its own direction FSM.
- Per-lane enter/exit pulses are merged into a saturating occupancy counter with full/empty flags.
- Adds stall timeout and a lane fault pulse.
- Sits between the raw sensor pins and the display/gate-control logic of the car park top level.

Parameters:
- N_LANES, 2: number of independent entry/exit lanes (1..8).
- CAPACITY, 15: maximum occupancy; count never exceeds it.
- DB_CYCLES, 4: consecutive stable samples required before a filtered sensor bit changes (>=1).
- TIMEOUT_CYCLES, 1000: cycles a lane may stay in one non-idle state before it aborts; 0 disables the timeout.
- CNT_W, $clog2(CAPACITY+1): derived width of the count output (localparam).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- a  in  N_LANES  per-lane outer sensor, 1 = beam blocked.
- b  in  N_LANES  per-lane inner sensor, 1 = beam blocked.
- enter  out  N_LANES  one-cycle pulse per completed entry, per lane.
- exit  out  N_LANES  one-cycle pulse per completed exit, per lane.
- count  out  CNT_W  current occupancy.
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.
- fault  out  N_LANES  one-cycle pulse when a lane times out.
- sat_err  out  1  one-cycle pulse when an update was clamped.

Behaviour:
- Reset (synchronous, active-high, clk edge with reset=1):
  - all lane FSMs go to WAITING; debounce filters are cleared to 0.
  - debounce and timeout counters are cleared; count is 0.
  - Outputs after reset: enter=exit=fault=0, sat_err=0, count=0, empty=1, full=0.
  - Reset asserted mid-sequence aborts that sequence silently, with no pulses.
- Debounce, per bit:
  - Filtered value changes only after the raw input differs from it for DB_CYCLES consecutive samples.
  - Any sample equal to the filtered value restarts the run.
  - With DB_CYCLES=1, latency is 1 cycle from raw to filtered.
- Lane FSM, decoded on filtered (a,b); any combination not listed holds the current state:
  - WAITING: 10 -> IN1; 01 -> OUT1.
  - IN1: 11 -> IN2; 00 -> WAITING.
  - IN2: 01 -> IN3; 10 -> IN1.
  - IN3: 00 -> IN_DONE; 11 -> IN2.
  - IN_DONE: enter[i]=1 for exactly one cycle, then WAITING unconditionally.
  - OUT1: 11 -> OUT2; 00 -> WAITING.
  - OUT2: 10 -> OUT3; 01 -> OUT1.
  - OUT3: 00 -> OUT_DONE; 11 -> OUT2.
  - OUT_DONE: exit[i]=1 for exactly one cycle, then WAITING.
  - Unused encodings -> WAITING.
  - Two-bit jumps (e.g. IN1 seeing 01) are ignored: the lane holds state.
- Timeout:
  - Per-lane counter clears on every state change and while in WAITING.
  - In any other state it increments; reaching TIMEOUT_CYCLES forces WAITING and pulses fault[i] for one cycle, with no enter/exit.
- Counter:
  - delta = popcount(enter) - popcount(exit), evaluated in the pulse cycle; count updates on the next edge.
  - Simultaneous entry and exit on different lanes net out; count is unchanged.
  - Result > CAPACITY clamps to CAPACITY; result < 0 clamps to 0. Either clamp pulses sat_err the cycle after the clamped update.
  - full and empty are combinational from the registered count.
- End-to-end latency: the filtered-00 edge in IN3 -> enter pulse one cycle later -> count changes one cycle after that.

Decomposition:
- Shared package (car_park_pkg): lane state encodings (4-bit, WAITING=0), and sensor pattern constants IDLE=00, OUTER=10, BOTH=11, INNER=01.
- Sub-module car_park_lane: one debounce pair, the FSM and the timeout counter per lane, instantiated N_LANES times via generate.
- Top level owns the popcount adder, the saturating counter and the flags.

Test Plan (N_LANES=2, CAPACITY=3, DB_CYCLES=2, TIMEOUT_CYCLES=16):
1. Lane 0 raw sequence 00,10,11,01,00, each held 4 cycles -> single enter[0] pulse; count 0->1; empty falls the cycle count becomes 1.
2. Lane 1 enters from the inside, sequence 00,01,11,10,00 -> exit[1] pulse; count 1->0; no sat_err.
3. Four consecutive lane-0 entries -> count 1,2,3,3; full=1 after the third; sat_err pulses once on the fourth.
4. Lane 0 entry and lane 1 exit completing in the same cycle with count=2 -> enter[0] and exit[1] both pulse; count stays 2.
5. 1-cycle glitches on a[0] while idle -> no state change, no pulses. Lane 0 parked at 11 for 20 cycles -> fault[0] pulses at the 16th cycle in IN2 and the lane returns to WAITING; count unchanged.
6. Reset asserted while lane 0 is in IN3 -> the following 00 produces no enter pulse; count=0, empty=1.
